// File: rtl/pma_rule_table.sv
// pma_rule_table
// Runtime-programmable physical-memory-attribute rule table. The table holds
// NrRules base/length regions, each tagged with {C,X,NI} attributes. It is
// written and read through a request/grant register port. An address lookup
// is answered by a scan FSM that evaluates one rule per cycle.
//
// Optional feature: define PMA_RULE_TABLE_LOCK_EN to enable the sticky write
// lock. When it is undefined, cfg_lock_i is ignored and lock_o reads 0.
//
// Ports
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   cfg_req_i/cfg_gnt_o  : register access request / grant (grant only in IDLE)
//   cfg_we_i             : 1 = write, 0 = read
//   cfg_idx_i            : rule index
//   cfg_field_i          : 0 = base, 1 = length, 2 = attr {C,X,NI}, 3 = reserved
//   cfg_wdata_i          : write data
//   cfg_rdata_o          : read data, valid with cfg_rvalid_o one cycle after grant
//   cfg_lock_i, lock_o   : set sticky lock / lock state
//   lkp_valid_i/ready_o  : lookup request handshake, lkp_addr_i is the address
//   rsp_valid_o/ready_i  : response handshake
//   rsp_nonidem_o, rsp_exec_o, rsp_cache_o, rsp_hit_o : lookup result
module pma_rule_table #(
    parameter int unsigned NrRules = 16,
    parameter int unsigned IdxW    = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cfg_req_i,
    output logic            cfg_gnt_o,
    input  logic            cfg_we_i,
    input  logic [IdxW-1:0] cfg_idx_i,
    input  logic [1:0]      cfg_field_i,
    input  logic [63:0]     cfg_wdata_i,
    output logic [63:0]     cfg_rdata_o,
    output logic            cfg_rvalid_o,
    input  logic            cfg_lock_i,
    output logic            lock_o,
    input  logic            lkp_valid_i,
    output logic            lkp_ready_o,
    input  logic [63:0]     lkp_addr_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic            rsp_nonidem_o,
    output logic            rsp_exec_o,
    output logic            rsp_cache_o,
    output logic            rsp_hit_o
);

    localparam int unsigned AddrW = 64;
    localparam int unsigned AttrW = 3;

    localparam logic [1:0] FieldBase = 2'd0;
    localparam logic [1:0] FieldLen  = 2'd1;
    localparam logic [1:0] FieldAttr = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    logic [AddrW-1:0] base_q [NrRules];
    logic [AddrW-1:0] len_q  [NrRules];
    logic [AttrW-1:0] attr_q [NrRules];

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic             hit_q, hit_d;
    logic             ni_q, ni_d;
    logic             x_q, x_d;
    logic             c_q, c_d;
    logic             xany_q, xany_d;
    logic             match;

    logic [AddrW-1:0] rdata_q, rdata_d;
    logic             rvalid_q;
    logic             lock_q;
    logic             idx_ok;
    logic             wr_en;

    // Sticky lock, cleared only by reset
`ifdef PMA_RULE_TABLE_LOCK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
        end else if (cfg_lock_i) begin
            lock_q <= 1'b1;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = cfg_lock_i;
    assign lock_q      = 1'b0;
`endif

    assign lock_o = lock_q;

    // Config port: granted only while idle, so the table never changes mid-scan
    assign cfg_gnt_o   = cfg_req_i && (state_q == ST_IDLE);
    assign lkp_ready_o = (state_q == ST_IDLE) && !cfg_req_i;
    assign idx_ok      = ({1'b0, cfg_idx_i} < (IdxW+1)'(NrRules));
    assign wr_en       = cfg_gnt_o && cfg_we_i && !lock_q && idx_ok
                         && (cfg_field_i != 2'd3);

    // Read data mux; out-of-range index and reserved field read as zero
    always_comb begin
        rdata_d = '0;
        if (idx_ok) begin
            unique case (cfg_field_i)
                FieldBase: rdata_d = base_q[cfg_idx_i];
                FieldLen:  rdata_d = len_q[cfg_idx_i];
                FieldAttr: rdata_d = AddrW'(attr_q[cfg_idx_i]);
                default:   rdata_d = '0;
            endcase
        end
    end

    // Rule storage and read-return registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NrRules); i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
                attr_q[i] <= '0;
            end
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= cfg_gnt_o && !cfg_we_i;
            if (cfg_gnt_o && !cfg_we_i) begin
                rdata_q <= rdata_d;
            end
            if (wr_en) begin
                unique case (cfg_field_i)
                    FieldBase: base_q[cfg_idx_i] <= cfg_wdata_i;
                    FieldLen:  len_q[cfg_idx_i]  <= cfg_wdata_i;
                    FieldAttr: attr_q[cfg_idx_i] <= cfg_wdata_i[AttrW-1:0];
                    default:   ;
                endcase
            end
        end
    end

    assign cfg_rdata_o  = rdata_q;
    assign cfg_rvalid_o = rvalid_q;

    // Scan FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            hit_q   <= 1'b0;
            ni_q    <= 1'b0;
            x_q     <= 1'b0;
            c_q     <= 1'b0;
            xany_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            hit_q   <= hit_d;
            ni_q    <= ni_d;
            x_q     <= x_d;
            c_q     <= c_d;
            xany_q  <= xany_d;
        end
    end

    // Scan FSM next state; one rule per SCAN cycle, 65-bit end so no wrap
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        hit_d   = hit_q;
        ni_d    = ni_q;
        x_d     = x_q;
        c_d     = c_q;
        xany_d  = xany_q;
        match   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (lkp_valid_i && !cfg_req_i) begin
                    addr_d  = lkp_addr_i;
                    idx_d   = '0;
                    hit_d   = 1'b0;
                    ni_d    = 1'b0;
                    x_d     = 1'b0;
                    c_d     = 1'b0;
                    xany_d  = 1'b0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                match  = (addr_q >= base_q[idx_q])
                         && ({1'b0, addr_q} < ({1'b0, base_q[idx_q]} + {1'b0, len_q[idx_q]}));
                hit_d  = hit_q | match;
                ni_d   = ni_q | (match & attr_q[idx_q][0]);
                x_d    = x_q  | (match & attr_q[idx_q][1]);
                c_d    = c_q  | (match & attr_q[idx_q][2]);
                xany_d = xany_q | attr_q[idx_q][1];
                if (idx_q == IdxW'(NrRules - 1)) begin
                    state_d = ST_RESP;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response is gated so all rsp_* read zero outside RESP; exec defaults
    // to allowed when no rule restricts execution
    assign rsp_valid_o   = (state_q == ST_RESP);
    assign rsp_hit_o     = rsp_valid_o & hit_q;
    assign rsp_nonidem_o = rsp_valid_o & ni_q;
    assign rsp_cache_o   = rsp_valid_o & c_q;
    assign rsp_exec_o    = rsp_valid_o & (xany_q ? x_q : 1'b1);

endmodule

// File: tb/tb_pma_rule_table.sv
// Self-checking bench for pma_rule_table: directed scenarios plus a randomized
// mix of writes, reads and lookups compared to a rule-list reference model.
module tb_pma_rule_table;

    localparam int NR = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_req, cfg_gnt, cfg_we, cfg_rvalid, cfg_lock, lock;
    logic [3:0]  cfg_idx;
    logic [1:0]  cfg_field;
    logic [63:0] cfg_wdata, cfg_rdata, lkp_addr;
    logic        lkp_valid, lkp_ready, rsp_valid, rsp_ready;
    logic        rsp_ni, rsp_x, rsp_c, rsp_hit;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [63:0] m_base [NR];
    logic [63:0] m_len  [NR];
    logic [2:0]  m_attr [NR];
    logic        m_lock;

    pma_rule_table #(.NrRules(16), .IdxW(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_req_i(cfg_req), .cfg_gnt_o(cfg_gnt), .cfg_we_i(cfg_we),
        .cfg_idx_i(cfg_idx), .cfg_field_i(cfg_field), .cfg_wdata_i(cfg_wdata),
        .cfg_rdata_o(cfg_rdata), .cfg_rvalid_o(cfg_rvalid),
        .cfg_lock_i(cfg_lock), .lock_o(lock),
        .lkp_valid_i(lkp_valid), .lkp_ready_o(lkp_ready), .lkp_addr_i(lkp_addr),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_nonidem_o(rsp_ni), .rsp_exec_o(rsp_x), .rsp_cache_o(rsp_c),
        .rsp_hit_o(rsp_hit)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < NR; i++) begin
            m_base[i] = '0; m_len[i] = '0; m_attr[i] = '0;
        end
        m_lock = 1'b0;
    endfunction

    function automatic void model_write(input int idx, input int field, input logic [63:0] d);
        if (m_lock || idx >= NR) return;
        case (field)
            0: m_base[idx] = d;
            1: m_len[idx]  = d;
            2: m_attr[idx] = d[2:0];
            default: ;
        endcase
    endfunction

    function automatic logic [63:0] model_read(input int idx, input int field);
        if (idx >= NR) return '0;
        case (field)
            0: return m_base[idx];
            1: return m_len[idx];
            2: return {61'd0, m_attr[idx]};
            default: return '0;
        endcase
    endfunction

    // Returns {hit, NI, X, C} from the region list using 65-bit end arithmetic
    function automatic logic [3:0] model_lookup(input logic [63:0] a);
        logic hit = 0, ni = 0, x = 0, c = 0, xany = 0;
        logic [64:0] lim;
        for (int i = 0; i < NR; i++) begin
            lim = 65'(m_base[i]) + 65'(m_len[i]);
            if (m_attr[i][1]) xany = 1;
            if (a >= m_base[i] && 65'(a) < lim) begin
                hit = 1;
                if (m_attr[i][0]) ni = 1;
                if (m_attr[i][1]) x = 1;
                if (m_attr[i][2]) c = 1;
            end
        end
        return {hit, ni, (xany ? x : 1'b1), c};
    endfunction

    // Bus helpers: called at posedge+1, return at posedge+1
    task automatic cfg_write(input int idx, input int field, input logic [63:0] d);
        cfg_req = 1; cfg_we = 1; cfg_idx = 4'(idx); cfg_field = 2'(field); cfg_wdata = d;
        @(posedge clk); #1;
        cfg_req = 0; cfg_we = 0;
        model_write(idx, field, d);
    endtask

    task automatic cfg_read(input int idx, input int field, output logic [63:0] d, output logic v);
        cfg_req = 1; cfg_we = 0; cfg_idx = 4'(idx); cfg_field = 2'(field);
        @(posedge clk); #1;
        cfg_req = 0;
        d = cfg_rdata; v = cfg_rvalid;
    endtask

    task automatic do_lookup(input logic [63:0] a, output logic [3:0] r, output int lat);
        lkp_addr = a; lkp_valid = 1;
        @(posedge clk); #1;
        lkp_valid = 0; lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        n_vec++;
        if (rsp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL lookup_timeout addr=%h rsp_valid=%b required 1", a, rsp_valid);
        end
        r = {rsp_hit, rsp_ni, rsp_x, rsp_c};
    endtask

    task automatic rsp_release();
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if ({cfg_gnt, cfg_rvalid, lock, rsp_valid, rsp_hit, rsp_ni, rsp_x, rsp_c, lkp_ready} !== 9'b000000001
            || cfg_rdata !== 64'd0) begin
            n_err++;
            $display("FAIL reset_outputs gnt=%b rvalid=%b lock=%b rsp=%b%b%b%b%b ready=%b rdata=%h required all 0, ready 1",
                     cfg_gnt, cfg_rvalid, lock, rsp_valid, rsp_hit, rsp_ni, rsp_x, rsp_c, lkp_ready, cfg_rdata);
        end
    endtask

    task automatic test_empty_lookup();
        logic [3:0] r; int lat;
        do_lookup(64'h8000_0000, r, lat);
        n_vec++;
        if (lat !== NR + 1) begin
            n_err++; $display("FAIL empty_latency got %0d required %0d", lat, NR + 1);
        end
        n_vec++;
        if (r !== 4'b0010) begin
            n_err++; $display("FAIL empty_result {hit,ni,x,c} got %b required 0010", r);
        end
        rsp_release();
        // Back-to-back: next lookup accepted immediately after the response
        n_vec++;
        if (lkp_ready !== 1'b1) begin
            n_err++; $display("FAIL ready_after_resp got %b required 1", lkp_ready);
        end
    endtask

    task automatic test_entry0();
        logic [3:0] r; int lat;
        cfg_write(0, 0, 64'h8000_0000);
        cfg_write(0, 1, 64'h1000);
        cfg_write(0, 2, 64'b110);
        do_lookup(64'h8000_0FFF, r, lat);
        n_vec++;
        if (r !== 4'b1011 || r !== model_lookup(64'h8000_0FFF)) begin
            n_err++; $display("FAIL entry0_last_byte got %b required 1011", r);
        end
        rsp_release();
        do_lookup(64'h8000_1000, r, lat);
        n_vec++;
        if (r !== 4'b0000) begin
            n_err++; $display("FAIL entry0_past_end got %b required 0000", r);
        end
        rsp_release();
    endtask

    task automatic test_top_entry();
        logic [3:0] r; int lat;
        cfg_write(15, 0, 64'hFFFF_FFFF_FFFF_F000);
        cfg_write(15, 1, 64'h1000);
        cfg_write(15, 2, 64'b001);
        do_lookup(64'hFFFF_FFFF_FFFF_FFFF, r, lat);
        n_vec++;
        if (r[3] !== 1'b1 || r[2] !== 1'b1 || r !== model_lookup(64'hFFFF_FFFF_FFFF_FFFF)) begin
            n_err++; $display("FAIL top_entry_no_wrap got %b required hit=1 ni=1 (%b)", r,
                              model_lookup(64'hFFFF_FFFF_FFFF_FFFF));
        end
        rsp_release();
    endtask

    task automatic test_cfg_priority();
        logic [3:0] r; int lat;
        cfg_req = 1; cfg_we = 1; cfg_idx = 4'd0; cfg_field = 2'd2; cfg_wdata = 64'b001;
        lkp_valid = 1; lkp_addr = 64'h8000_0000;
        #1;
        n_vec++;
        if (cfg_gnt !== 1'b1 || lkp_ready !== 1'b0) begin
            n_err++; $display("FAIL priority gnt=%b ready=%b required gnt=1 ready=0", cfg_gnt, lkp_ready);
        end
        @(posedge clk); #1;
        cfg_req = 0; cfg_we = 0;
        model_write(0, 2, 64'b001);
        do_lookup(64'h8000_0000, r, lat);
        n_vec++;
        if (r !== model_lookup(64'h8000_0000) || r !== 4'b1110) begin
            n_err++; $display("FAIL priority_new_value got %b required 1110", r);
        end
        rsp_release();
    endtask

    task automatic test_random();
        logic [3:0] r; int lat; logic [63:0] d, a; logic v;
        int idx, field;
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    idx = $urandom_range(3, 14);
                    field = $urandom_range(0, 3);
                    case (field)
                        0: d = 64'($urandom_range(0, 15)) << 12;
                        1: d = 64'($urandom_range(0, 3)) << 12;
                        default: d = {$urandom, $urandom};
                    endcase
                    cfg_write(idx, field, d);
                end
                1: begin
                    idx = $urandom_range(0, 15);
                    field = $urandom_range(0, 3);
                    cfg_read(idx, field, d, v);
                    n_vec++;
                    if (v !== 1'b1 || d !== model_read(idx, field)) begin
                        n_err++; $display("FAIL rand_read idx=%0d field=%0d got %h v=%b required %h",
                                          idx, field, d, v, model_read(idx, field));
                    end
                end
                default: begin
                    a = 64'($urandom_range(0, 32'h11000));
                    if ($urandom_range(0, 3) == 0) a = 64'h8000_0000 + 64'($urandom_range(0, 32'h1800));
                    do_lookup(a, r, lat);
                    n_vec++;
                    if (r !== model_lookup(a) || lat !== NR + 1) begin
                        n_err++; $display("FAIL rand_lookup addr=%h got %b lat=%0d required %b lat=%0d",
                                          a, r, lat, model_lookup(a), NR + 1);
                    end
                    rsp_release();
                end
            endcase
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] r; int lat; logic ok = 1;
        do_lookup(64'h0000_1000, r, lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (!rsp_valid || lkp_ready || {rsp_hit, rsp_ni, rsp_x, rsp_c} !== r) ok = 0;
        end
        n_vec++;
        if (ok !== 1'b1 || r !== model_lookup(64'h0000_1000)) begin
            n_err++; $display("FAIL backpressure_hold got %b now %b%b%b%b valid=%b ready=%b required %b stable",
                              r, rsp_hit, rsp_ni, rsp_x, rsp_c, rsp_valid, lkp_ready, model_lookup(64'h0000_1000));
        end
        rsp_release();
    endtask

    task automatic test_lock();
        logic [63:0] d; logic v; logic exp_lock;
        cfg_lock = 1;
        @(posedge clk); #1;
        cfg_lock = 0;
`ifdef PMA_RULE_TABLE_LOCK_EN
        m_lock = 1;
`endif
        exp_lock = m_lock;
        n_vec++;
        if (lock !== exp_lock) begin
            n_err++; $display("FAIL lock_state got %b required %b", lock, exp_lock);
        end
        cfg_write(2, 0, 64'h1234);
        cfg_read(2, 0, d, v);
        n_vec++;
        if (v !== 1'b1 || d !== model_read(2, 0) || d !== (exp_lock ? 64'd0 : 64'h1234)) begin
            n_err++; $display("FAIL lock_write_drop got %h v=%b required %h", d, v, model_read(2, 0));
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [63:0] d; logic v;
        lkp_addr = 64'h8000_0000; lkp_valid = 1;
        @(posedge clk); #1;
        lkp_valid = 0;
        repeat (5) @(posedge clk);
        #1 rst_n = 0;
        #1;
        n_vec++;
        if (rsp_valid !== 1'b0 || lkp_ready !== 1'b1 || lock !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_scan valid=%b ready=%b lock=%b required 0 1 0",
                              rsp_valid, lkp_ready, lock);
        end
        model_clear();
        @(posedge clk); #1 rst_n = 1;
        cfg_read(0, 0, d, v);
        n_vec++;
        if (d !== model_read(0, 0)) begin
            n_err++; $display("FAIL table_cleared got %h required %h", d, model_read(0, 0));
        end
    endtask

    initial begin
        rst_n = 0; cfg_req = 0; cfg_we = 0; cfg_idx = '0; cfg_field = '0; cfg_wdata = '0;
        cfg_lock = 0; lkp_valid = 0; lkp_addr = '0; rsp_ready = 0;
        model_clear();
        repeat (3) @(posedge clk);
        test_reset();
        @(posedge clk); #1 rst_n = 1;
        test_empty_lookup();
        test_entry0();
        test_top_entry();
        test_cfg_priority();
        test_random();
        test_backpressure();
        test_lock();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pma_rule_table.md
# pma_rule_table

Runtime-programmable physical-memory-attribute rule table. It holds up to `NrRules` base/length regions, each tagged with non-idempotent, execute and cacheable attributes. Software or boot logic writes the table through a request/grant register port. The table answers address lookups with a sequential scan FSM that evaluates one rule per cycle. It is the writable counterpart of the static region rules in the core configuration: it produces and serves the rule data that the compile-time region checks only read.

## Interface
Parameters:
- `NrRules`, 16: number of rule entries; legal range 1..16.
- `IdxW`, 4: width of the rule index; fixed at 4.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; asynchronous, active-low.
- `cfg_req_i` in 1: register access request.
- `cfg_gnt_o` out 1: access accepted this cycle.
- `cfg_we_i` in 1: 1 = write, 0 = read.
- `cfg_idx_i` in 4: rule index.
- `cfg_field_i` in 2: field select; 0 = base, 1 = length, 2 = attr {C,X,NI} in bits [2:0], 3 = reserved.
- `cfg_wdata_i` in 64: write data.
- `cfg_rdata_o` out 64: read data.
- `cfg_rvalid_o` out 1: read data valid.
- `cfg_lock_i` in 1: set the sticky lock.
- `lock_o` out 1: lock state.
- `lkp_valid_i` in 1: lookup request valid.
- `lkp_ready_o` out 1: lookup request ready.
- `lkp_addr_i` in 64: physical address to look up.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response ready.
- `rsp_nonidem_o` out 1: address is in a non-idempotent region.
- `rsp_exec_o` out 1: address is executable.
- `rsp_cache_o` out 1: address is cacheable.
- `rsp_hit_o` out 1: at least one rule matched.

## Operation
- Storage per entry: base[63:0], len[63:0], attr[2:0]. All entries reset to 0.
- Match rule: `addr >= base && {1'b0,addr} < 65'(base) + len`. The sum is 65 bits wide, so there is no wrap-around. A rule with len = 0 never matches.
- FSM states and transitions:
  - IDLE: `lkp_ready_o = !cfg_req_i`. On a lookup handshake, latch the address, clear the accumulators, set idx = 0, go to SCAN.
  - SCAN: each cycle, evaluate entry idx and OR its result into hit, NI, X and C. Track `xany |= attr.X` regardless of match. When idx == NrRules-1, go to RESP; otherwise increment idx.
  - RESP: hold `rsp_valid_o` and all response data stable until `rsp_ready_i`, then go to IDLE.
- Execute result: if no entry has attr.X set, `rsp_exec_o = 1`; otherwise `rsp_exec_o` is the accumulated X match.
- Config access:
  - `cfg_gnt_o = cfg_req_i && state == IDLE`. Config has priority over a lookup presented in the same cycle.
  - Writes to a reserved field, to idx >= NrRules, or any write while locked: granted and dropped.
  - Reads: `cfg_rdata_o` is valid the cycle after grant, with `cfg_rvalid_o = 1` for one cycle. Attr reads return zero-extended attr. Reserved field or idx >= NrRules reads return 0.
- Lock: `cfg_lock_i` sets lock. Only reset clears it.

## Timing
- Reset values: state IDLE; `lkp_ready_o` = 1 when no cfg request; `rsp_*`, `cfg_gnt_o`, `cfg_rvalid_o`, `cfg_rdata_o` and `lock_o` = 0.
- Lookup latency: handshake in cycle 0; `rsp_valid_o` rises in cycle NrRules+1. Maximum throughput is one lookup per NrRules+2 cycles with `rsp_ready_i` held high.
- A write granted in cycle t affects lookups accepted in cycle t+1 or later. No write can land during SCAN or RESP, because grant is given only in IDLE.
- Back-pressure: when `rsp_ready_i` is low, the FSM stays in RESP indefinitely and the response outputs stay frozen.
- Reset asserted mid-scan or mid-response: the FSM returns to IDLE immediately, the table is cleared and the in-flight response is lost.

## Configuration
- `PMA_RULE_TABLE_LOCK_EN` defined: lock behaves as described above.
- `PMA_RULE_TABLE_LOCK_EN` undefined: `cfg_lock_i` is ignored, `lock_o` is tied to 0, and writes are always accepted.

## Test plan
- Reset then lookup 0x8000_0000: response at cycle 17 (NrRules = 16) with hit = 0, NI = 0, X = 1, C = 0.
- Program entry 0 with base 0x8000_0000, len 0x1000, attr 0b110:
  - lookup 0x8000_0FFF gives hit = 1, X = 1, C = 1, NI = 0;
  - lookup 0x8000_1000 gives hit = 0, X = 0, C = 0.
- Program entry 15 with base 0xFFFF_FFFF_FFFF_F000, len 0x1000, attr NI: lookup 0xFFFF_FFFF_FFFF_FFFF gives NI = 1 and hit = 1 (no 65-bit overflow).
- Assert `cfg_req_i` and `lkp_valid_i` in the same IDLE cycle: `cfg_gnt_o` = 1 and `lkp_ready_o` = 0. The lookup is accepted the next cycle and sees the new value.
- Set lock, write base 0x1234 to entry 2, then read it back: `cfg_rdata_o` = 0 one cycle after grant. With the lock macro undefined, the read returns 0x1234.
- Hold `rsp_ready_i` = 0 for 5 cycles in RESP: outputs stay stable and `lkp_ready_o` = 0. Assert `rst_ni` low mid-SCAN: `rsp_valid_o` = 0 and `lkp_ready_o` = 1 immediately.
